// File: rtl/transceiver_arbiter.sv
// transceiver_arbiter: shares one two-phase (toggle) req/ack/data output channel
// between N two-phase requesters. One pending requester is granted at a time,
// round-robin, its word is registered onto data_out and the downstream ack is
// returned to that requester only.
// Optional feature macro: ARB_FIXED_PRIORITY_EN -- when defined the round-robin
// pointer stays at 0, so the lowest pending index always wins.
// Data width is `SIZE (defaults to 8 when not defined elsewhere).

`ifndef SIZE
`define SIZE 8
`endif

module transceiver_arbiter #(
    parameter int id = -1,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_in,
    output logic [N-1:0]         ack_in,
    input  logic [N*`SIZE-1:0]   data_in,
    output logic                 req_out,
    input  logic                 ack_out,
    output logic [`SIZE-1:0]     data_out,
    output logic                 busy,
    output logic [IW-1:0]        grant
);

    // Reject configurations the index logic cannot represent.
    if (N < 2 || N > 16 || IW < $clog2(N)) begin : g_bad_cfg
        $error("transceiver_arbiter (router %0d): unsupported N/IW combination", id);
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       ack_q, ack_d;
    logic               req_out_q, req_out_d;
    logic [`SIZE-1:0]   data_q, data_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;

    // Arbitration scratch
    logic [N-1:0]       pending;
    logic               found_hi, found_lo;
    logic [IW-1:0]      g_hi, g_lo, g_sel;
    logic [`SIZE-1:0]   word_sel;

    // Round-robin pick: first pending index at or above rr, otherwise the
    // first pending index overall (which is then below rr, i.e. wrapped).
    always_comb begin
        pending  = req_in ^ ack_q;
        found_hi = 1'b0;
        found_lo = 1'b0;
        g_hi     = '0;
        g_lo     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_hi && pending[i] && (IW'(i) >= rr_q)) begin
                found_hi = 1'b1;
                g_hi     = IW'(i);
            end
            if (!found_lo && pending[i]) begin
                found_lo = 1'b1;
                g_lo     = IW'(i);
            end
        end
        g_sel    = found_hi ? g_hi : g_lo;
        word_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == g_sel) word_sel = data_in[i*`SIZE +: `SIZE];
        end
    end

    // Next-state: grant from IDLE, complete the handshake from BUSY.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        req_out_d = req_out_q;
        data_d    = data_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        case (state_q)
            IDLE: begin
                if (found_lo) begin
                    data_d    = word_sel;
                    grant_d   = g_sel;
                    req_out_d = ~req_out_q;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Only the granted requester's ack is ever touched; req_in
                // activity elsewhere just changes who is pending next time.
                if (ack_out == req_out_q) begin
                    for (int i = 0; i < N; i++) begin
                        if (IW'(i) == grant_q) ack_d[i] = ~ack_q[i];
                    end
`ifdef ARB_FIXED_PRIORITY_EN
                    rr_d = '0;
`else
                    rr_d = (grant_q == IW'(N-1)) ? '0 : grant_q + 1'b1;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            req_out_q <= 1'b0;
            data_q    <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            req_out_q <= req_out_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
        end
    end

    assign ack_in   = ack_q;
    assign req_out  = req_out_q;
    assign data_out = data_q;
    assign grant    = grant_q;
    assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_transceiver_arbiter.sv
// Bench for transceiver_arbiter: directed scenarios followed by random
// requester/downstream traffic, all checked every cycle against a
// transfer-level reference model kept in the bench.

`ifndef SIZE
`define SIZE 8
`endif

module tb_transceiver_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = `SIZE;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_in = '0;
    logic [N-1:0]     ack_in;
    logic [N*W-1:0]   data_in;
    logic             req_out;
    logic             ack_out = 1'b0;
    logic [W-1:0]     data_out;
    logic             busy;
    logic [IW-1:0]    grant;
    logic [W-1:0]     w [N];

    always_comb for (int i = 0; i < N; i++) data_in[i*W +: W] = w[i];

    always #5 clk = ~clk;

    transceiver_arbiter #(.id(3), .N(N), .IW(IW)) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .ack_in(ack_in),
        .data_in(data_in), .req_out(req_out), .ack_out(ack_out),
        .data_out(data_out), .busy(busy), .grant(grant)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: which requester owns the channel, what it sent,
    // how many acks each requester has received (as a toggle), rr pointer.
    logic [N-1:0] m_ack;
    int           m_rr, m_g;
    bit           m_busy, m_ro;
    logic [W-1:0] m_do;
    bit           auto_ds = 1'b0;
    int           ds_wait = 0;
    logic         p_ro = 1'b0;
    int           gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack_in",   32'(ack_in),   32'(m_ack));
        chk("req_out",  32'(req_out),  32'(m_ro));
        chk("data_out", 32'(data_out), 32'(m_do));
        chk("busy",     32'(busy),     32'(m_busy));
        chk("grant",    32'(grant),    32'(m_g));
    endtask

    task automatic model_reset();
        m_ack = '0; m_rr = 0; m_g = 0; m_busy = 0; m_ro = 0; m_do = '0;
    endtask

    // One clock: capture inputs seen at the edge, advance model, compare.
    task automatic step();
        logic [N-1:0] r, pend;
        logic         a;
        bit           rs;
        r = req_in; a = ack_out; rs = reset;
        @(posedge clk); #1;
        if (rs) begin
            model_reset();
        end else if (!m_busy) begin
            pend = r ^ m_ack;
            if (pend != 0) begin
                // Walk the circular order backwards so the closest to rr wins.
                for (int k = N-1; k >= 0; k--)
                    if (pend[(m_rr + k) % N]) m_g = (m_rr + k) % N;
                m_do = w[m_g]; m_ro = ~m_ro; m_busy = 1;
            end
        end else if (a == m_ro) begin
            m_ack[m_g] = ~m_ack[m_g];
`ifdef ARB_FIXED_PRIORITY_EN
            m_rr = 0;
`else
            m_rr = (m_g + 1) % N;
`endif
            m_busy = 0;
        end
        check_all();
        if (!rs && req_out !== p_ro) gq.push_back(int'(grant));
        p_ro = req_out;
        if (auto_ds && ack_out != m_ro) begin
            if (ds_wait == 0) begin
                ack_out = m_ro;
                ds_wait = $urandom_range(0, 2);
            end else ds_wait--;
        end
    endtask

    task automatic do_reset(input logic [N-1:0] req_val);
        req_in = req_val; ack_out = 1'b0; reset = 1'b1;
        #1;
        model_reset(); p_ro = 1'b0;
        check_all();
        step(); step();
        reset = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((m_busy || (req_in ^ m_ack) != 0) && n < max) begin
            step(); n++;
        end
        chk("drain_bound", 32'(n < max), 32'd1);
    endtask

    task automatic rnd_reqs();
        for (int i = 0; i < N; i++) begin
            if (req_in[i] == m_ack[i] && $urandom_range(0, 3) == 0) begin
                w[i] = W'($urandom);
                req_in[i] = ~req_in[i];
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) w[i] = '0;
        model_reset();

        // 1: reset state, idle for 10 cycles
        do_reset('0);
        repeat (10) step();

        // 2: single transfer from requester 1, one-flop loopback
        w[1] = 8'hA5; req_in[1] = 1'b1;
        step();
        chk("t2_data", 32'(data_out), 32'h0A5);
        chk("t2_grant", 32'(grant), 32'd1);
        ack_out = m_ro;
        step();
        chk("t2_ack", 32'(ack_in), 32'b0010);
        step();

        // 3: all four requesters together from rr=0
        do_reset('0);
        gq.delete();
        for (int i = 0; i < N; i++) w[i] = W'($urandom);
        req_in = ~req_in;
        auto_ds = 1'b1; ds_wait = 0;
        drain(60);
        chk("t3_count", 32'(gq.size()), 32'd4);
        for (int k = 0; k < gq.size(); k++) chk("t3_order", 32'(gq[k]), 32'(k));

        // 4: requester 3 granted, then 0 and 3 both pending -> 0 wins
        gq.delete();
        w[3] = 8'h33; req_in[3] = ~req_in[3];
        step();
        w[0] = 8'h00; req_in[0] = ~req_in[0];
        while (m_busy) step();
        w[3] = 8'h3C; req_in[3] = ~req_in[3];
        drain(40);
        chk("t4_count", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) chk("t4_wrap", 32'(gq[1]), 32'd0);

        // 5: downstream stalls 20 cycles, plus a protocol-violating retoggle
        auto_ds = 1'b0;
        w[2] = 8'h5A; req_in[2] = ~req_in[2];
        step();
        req_in[2] = ~req_in[2];
        repeat (20) step();
        chk("t5_busy", 32'(busy), 32'd1);
        ack_out = m_ro;
        step();
        auto_ds = 1'b1; ds_wait = 0;
        drain(40);

        // 6: reset during BUSY with requester 1 holding req_in=1
        auto_ds = 1'b0;
        do_reset('0);
        gq.delete();
        w[1] = 8'hC3; req_in = 4'b0010;
        step();
        chk("t6_busy", 32'(busy), 32'd1);
        do_reset(4'b0010);
        step();
        chk("t6_regrant", 32'(grant), 32'd1);
        chk("t6_resend", 32'(data_out), 32'h0C3);
        auto_ds = 1'b1; ds_wait = 0;
        drain(40);

        // Random traffic with random downstream latency
        for (int c = 0; c < 600; c++) begin
            rnd_reqs();
            step();
        end
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
